// File: rtl/inet_checksum_if.sv
// Stream bundle for the checksum engine: byte-qualified packet input, seed, 16-bit result output.
// Latency: none, wires only.
// Backpressure: input uses tvalid/tready; output uses tvalid/tready.
interface inet_checksum_if #(
    parameter int DATA_BYTES = 2
);
    // Packet input side.
    logic                    axis_i_tready;
    logic                    axis_i_tvalid;
    logic                    axis_i_tlast;
    logic [DATA_BYTES-1:0]   axis_i_tkeep;
    logic [8*DATA_BYTES-1:0] axis_i_tdata;

    // Per-packet initial sum, taken on the first beat of each packet.
    logic [15:0]             cfg_seed;

    // Checksum result side.
    logic                    axis_o_tready;
    logic                    axis_o_tvalid;
    logic                    axis_o_tlast;
    logic [15:0]             axis_o_tdata;
    logic                    axis_o_tuser;

    // Checksum engine view.
    modport slave (
        output axis_i_tready,
        input  axis_i_tvalid,
        input  axis_i_tlast,
        input  axis_i_tkeep,
        input  axis_i_tdata,
        input  cfg_seed,
        input  axis_o_tready,
        output axis_o_tvalid,
        output axis_o_tlast,
        output axis_o_tdata,
        output axis_o_tuser
    );

    // Packet source / result sink view.
    modport master (
        input  axis_i_tready,
        output axis_i_tvalid,
        output axis_i_tlast,
        output axis_i_tkeep,
        output axis_i_tdata,
        output cfg_seed,
        output axis_o_tready,
        input  axis_o_tvalid,
        input  axis_o_tlast,
        input  axis_o_tdata,
        input  axis_o_tuser
    );
endinterface

// File: rtl/inet_checksum.sv
// RFC 1071 one's-complement checksum over a byte-qualified stream, with seed, verify flag and optional zero substitution.
// Latency: a tlast beat accepted at edge T is in the finalise register after T and on the output after T+1.
// Backpressure: input stalls only when the finalise register is full and the output register is full and not ready.
module inet_checksum #(
    parameter int DATA_BYTES   = 2,
    parameter bit UDP_ZERO_SUB = 1'b0
) (
    input  logic           clk,
    input  logic           sresetn,
    inet_checksum_if.slave axis
);
    localparam int WORDS = DATA_BYTES / 2;
    // One bit of headroom above the minimum so the per-beat end-around
    // carry can never push the accumulator past its width.
    localparam int ACC_W = 18 + $clog2(WORDS);

    // ------------------------------------------------------------------
    // Beat sum: big-endian byte pairs, stream byte 0 at the MSB; bytes
    // with tkeep low are zero, which pads odd-length packets.
    // ------------------------------------------------------------------
    logic [15:0]      word_m [WORDS];
    logic [ACC_W-1:0] beat_sum;

    for (genvar j = 0; j < WORDS; j++) begin : g_word
        localparam int HI_BIT = 8*DATA_BYTES - 1 - 16*j;
        localparam int LO_BIT = HI_BIT - 8;
        localparam int HI_KEEP = DATA_BYTES - 1 - 2*j;
        localparam int LO_KEEP = DATA_BYTES - 2 - 2*j;
        assign word_m[j] = {
            axis.axis_i_tkeep[HI_KEEP] ? axis.axis_i_tdata[HI_BIT -: 8] : 8'h00,
            axis.axis_i_tkeep[LO_KEEP] ? axis.axis_i_tdata[LO_BIT -: 8] : 8'h00
        };
    end

    // Full-precision sum of the masked words of the current beat.
    always_comb begin
        beat_sum = '0;
        for (int j = 0; j < WORDS; j++) begin
            beat_sum = beat_sum + ACC_W'(word_m[j]);
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic             first_q,     first_d;
    logic [ACC_W-1:0] fin_sum_q,   fin_sum_d;
    logic             fin_valid_q, fin_valid_d;
    logic             o_valid_q,   o_valid_d;
    logic [15:0]      o_data_q,    o_data_d;
    logic             o_user_q,    o_user_d;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic in_fire;
    logic out_load;
    logic fin_move;

    // The output register can take a new value when empty or being drained.
    assign out_load = !o_valid_q || axis.axis_o_tready;
    // Input is accepted whenever the finalise register is free or about to empty.
    assign axis.axis_i_tready = !fin_valid_q || out_load;
    assign in_fire  = axis.axis_i_tvalid && axis.axis_i_tready;
    assign fin_move = fin_valid_q && out_load;

    // ------------------------------------------------------------------
    // Accumulate: end-around carry folded in every beat keeps acc bounded
    // for any packet length; the seed replaces acc on the first beat.
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_next;

    // Accumulator, first-beat flag and hand-off into the finalise register.
    always_comb begin
        acc_d       = acc_q;
        first_d     = first_q;
        fin_sum_d   = fin_sum_q;
        fin_valid_d = fin_valid_q;

        if (first_q) begin
            acc_base = ACC_W'(axis.cfg_seed);
        end else begin
            acc_base = ACC_W'(acc_q[15:0]) + (acc_q >> 16);
        end
        acc_next = acc_base + beat_sum;

        // Finalise register empties into the output register.
        if (fin_move) begin
            fin_valid_d = 1'b0;
        end

        if (in_fire) begin
            first_d = axis.axis_i_tlast;
            if (axis.axis_i_tlast) begin
                // Packet complete: park the sum and restart cleanly so the
                // next packet's first beat can be taken on the next edge.
                fin_sum_d   = acc_next;
                fin_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = acc_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Finalise: fold to 16 bits. The first fold leaves at most a 17-bit
    // value; the second settles it; the third only absorbs a carry that
    // the bounds above rule out, so every bit of the fold is consumed.
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] fold1;
    logic [16:0]      fold2;
    logic [15:0]      fold_s;
    logic [15:0]      cs;

    // Fold the finished sum and form the transmitted checksum.
    always_comb begin
        fold1  = ACC_W'(fin_sum_q[15:0]) + (fin_sum_q >> 16);
        fold2  = {1'b0, fold1[15:0]} + 17'(fold1[ACC_W-1:16]);
        fold_s = fold2[15:0] + {15'd0, fold2[16]};
        cs     = ~fold_s;
        // UDP reserves 0x0000 for "no checksum"; send the equivalent 0xFFFF.
        if (UDP_ZERO_SUB && (cs == 16'h0000)) begin
            cs = 16'hFFFF;
        end
    end

    // Output register loads from the finalise stage whenever it is free.
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_user_d  = o_user_q;
        if (out_load) begin
            o_valid_d = fin_valid_q;
            if (fin_valid_q) begin
                o_data_d = cs;
                o_user_d = (fold_s == 16'hFFFF);
            end
        end
    end

    // State registers; reset clears data too so outputs are never X.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            fin_sum_q   <= '0;
            fin_valid_q <= 1'b0;
            o_valid_q   <= 1'b0;
            o_data_q    <= 16'h0000;
            o_user_q    <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            first_q     <= first_d;
            fin_sum_q   <= fin_sum_d;
            fin_valid_q <= fin_valid_d;
            o_valid_q   <= o_valid_d;
            o_data_q    <= o_data_d;
            o_user_q    <= o_user_d;
        end
    end

    assign axis.axis_o_tvalid = o_valid_q;
    assign axis.axis_o_tlast  = 1'b1;
    assign axis.axis_o_tdata  = o_data_q;
    assign axis.axis_o_tuser  = o_user_q;

endmodule

// File: tb/tb_inet_checksum.sv
// Scoreboard bench: two engines (4-byte bus without zero substitution, 2-byte bus with it).
// Latency: results checked in order; selected packets also checked for 2-cycle latency.
// Backpressure: output ready is stalled to fill both result slots.
module tb_inet_checksum;
    logic clk = 1'b0;
    logic sresetn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Count rising edges; sampled at negedge, so stable there.
    always @(posedge clk) cyc <= cyc + 1;

    inet_checksum_if #(.DATA_BYTES(4)) if0 ();
    inet_checksum_if #(.DATA_BYTES(2)) if1 ();

    inet_checksum #(.DATA_BYTES(4), .UDP_ZERO_SUB(1'b0)) dut0 (
        .clk     (clk),
        .sresetn (sresetn),
        .axis    (if0.slave)
    );

    inet_checksum #(.DATA_BYTES(2), .UDP_ZERO_SUB(1'b1)) dut1 (
        .clk     (clk),
        .sresetn (sresetn),
        .axis    (if1.slave)
    );

    typedef struct {
        logic [15:0] d;
        logic        u;
        int          at_cyc;   // -1: latency not checked
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference checksum over a byte list: plain 32-bit sum, folded at the end.
    function automatic logic [16:0] model(input logic [7:0] b[$], input logic [15:0] seed);
        int unsigned sum;
        logic [15:0] w;
        sum = 32'(seed);
        for (int i = 0; i < b.size(); i += 2) begin
            w = {b[i], (i + 1 < b.size()) ? b[i+1] : 8'h00};
            sum = sum + 32'(w);
        end
        while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
        return {(sum[15:0] == 16'hFFFF), ~sum[15:0]};
    endfunction

    // One beat into dut0; called at a negedge, returns at a later negedge.
    task automatic send0(input logic [31:0] d, input logic [3:0] k, input logic last,
                         input logic [15:0] seed, input logic [15:0] ed, input logic eu,
                         input bit chk_lat);
        int   waitc = 0;
        exp_t e;
        if0.axis_i_tvalid = 1'b1;
        if0.axis_i_tdata  = d;
        if0.axis_i_tkeep  = k;
        if0.axis_i_tlast  = last;
        if0.cfg_seed      = seed;
        #1;
        while (!if0.axis_i_tready && waitc < 200) begin
            @(negedge clk); #1;
            waitc++;
        end
        if (!if0.axis_i_tready) begin
            checks++; errors++;
            $display("FAIL send0_timeout actual=stalled expected=accepted");
        end else if (last) begin
            e.d = ed; e.u = eu; e.at_cyc = chk_lat ? cyc + 2 : -1;
            q0.push_back(e);
        end
        @(negedge clk);
        if0.axis_i_tvalid = 1'b0;
    endtask

    task automatic send1(input logic [15:0] d, input logic last, input logic [15:0] seed,
                         input logic [15:0] ed, input logic eu);
        int   waitc = 0;
        exp_t e;
        if1.axis_i_tvalid = 1'b1;
        if1.axis_i_tdata  = d;
        if1.axis_i_tkeep  = 2'b11;
        if1.axis_i_tlast  = last;
        if1.cfg_seed      = seed;
        #1;
        while (!if1.axis_i_tready && waitc < 200) begin
            @(negedge clk); #1;
            waitc++;
        end
        if (!if1.axis_i_tready) begin
            checks++; errors++;
            $display("FAIL send1_timeout actual=stalled expected=accepted");
        end else if (last) begin
            e.d = ed; e.u = eu; e.at_cyc = -1;
            q1.push_back(e);
        end
        @(negedge clk);
        if1.axis_i_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d/%0d pending expected=0/0", q0.size(), q1.size());
        end
    endtask

    // Monitor for dut0: pops and compares on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (if0.axis_o_tvalid && if0.axis_o_tready) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut0_unexpected actual=%h expected=none", if0.axis_o_tdata);
                end else begin
                    e = q0.pop_front();
                    chk("dut0_result", {15'd0, if0.axis_o_tuser, if0.axis_o_tdata}, {15'd0, e.u, e.d});
                    chk("dut0_tlast", 32'(if0.axis_o_tlast), 32'd1);
                    if (e.at_cyc >= 0) chk("dut0_latency", 32'(cyc), 32'(e.at_cyc));
                end
            end
        end
    end

    // Monitor for dut1.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (if1.axis_o_tvalid && if1.axis_o_tready) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1_unexpected actual=%h expected=none", if1.axis_o_tdata);
                end else begin
                    e = q1.pop_front();
                    chk("dut1_result", {15'd0, if1.axis_o_tuser, if1.axis_o_tdata}, {15'd0, e.u, e.d});
                end
            end
        end
    end

    initial begin
        logic [15:0] ipw [10];
        logic [7:0]  bytes_q[$];
        logic [16:0] m;
        logic [15:0] seed_r;
        logic [31:0] d;
        logic [3:0]  k;
        int          len, nb, t0;

        ipw = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                16'h0000, 16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};

        sresetn = 1'b0;
        if0.axis_i_tvalid = 1'b0; if0.axis_i_tlast = 1'b0; if0.axis_i_tkeep = '0;
        if0.axis_i_tdata  = '0;   if0.cfg_seed = '0;      if0.axis_o_tready = 1'b1;
        if1.axis_i_tvalid = 1'b0; if1.axis_i_tlast = 1'b0; if1.axis_i_tkeep = '0;
        if1.axis_i_tdata  = '0;   if1.cfg_seed = '0;      if1.axis_o_tready = 1'b1;
        repeat (3) @(negedge clk);
        sresetn = 1'b1;
        #1;
        chk("rst_tvalid0", 32'(if0.axis_o_tvalid), 32'd0);
        chk("rst_tready0", 32'(if0.axis_i_tready), 32'd1);
        chk("rst_tvalid1", 32'(if1.axis_o_tvalid), 32'd0);
        chk("rst_tready1", 32'(if1.axis_i_tready), 32'd1);
        chk("rst_tdata_known", 32'($isunknown(if0.axis_o_tdata)), 32'd0);
        @(negedge clk);

        // IPv4 header on the 4-byte bus, then with its checksum filled in.
        send0(32'h4500_0073, 4'hF, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        send0(32'h0000_4000, 4'hF, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        send0(32'h4011_0000, 4'hF, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        send0(32'hc0a8_0001, 4'hF, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        send0(32'hc0a8_00c7, 4'hF, 1'b1, 16'h0, 16'hB861, 1'b0, 1'b0);
        send0(32'h4500_0073, 4'hF, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        send0(32'h0000_4000, 4'hF, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        send0(32'h4011_b861, 4'hF, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        send0(32'hc0a8_0001, 4'hF, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        send0(32'hc0a8_00c7, 4'hF, 1'b1, 16'h0, 16'h0000, 1'b1, 1'b0);

        // Same header on the 2-byte bus; verified header gives 0xFFFF by zero substitution.
        for (int i = 0; i < 10; i++) send1(ipw[i], i == 9, 16'h0, 16'hB861, 1'b0);
        for (int i = 0; i < 10; i++) send1((i == 5) ? 16'hb861 : ipw[i], i == 9, 16'h0, 16'hFFFF, 1'b1);
        send1(16'hFFFF, 1'b1, 16'h0, 16'hFFFF, 1'b1);
        send1(16'h1234, 1'b1, 16'h0, 16'hEDCB, 1'b0);

        // Odd length padding, seed with end-around carry, all-zero tkeep on tlast.
        send0(32'h0102_0304, 4'b1110, 1'b1, 16'h0, 16'hFBFD, 1'b0, 1'b0);
        send0(32'h0001_ABCD, 4'b1100, 1'b1, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0);
        send0(32'h1111_2222, 4'hF, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        send0(32'hFFFF_FFFF, 4'b0000, 1'b1, 16'h0, 16'hCCCC, 1'b0, 1'b0);
        // Seed changes mid-packet must be ignored.
        send0(32'h0001_0001, 4'hF, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b0);
        send0(32'h0002_0000, 4'hF, 1'b1, 16'h5555, 16'hFEFB, 1'b0, 1'b0);
        // No zero substitution on dut0: verified sum gives 0x0000.
        send0(32'hFFFF_0000, 4'b1100, 1'b1, 16'h0, 16'h0000, 1'b1, 1'b0);
        drain();

        // Back-to-back single-beat packets at full rate, 2-cycle latency each.
        t0 = cyc;
        for (int i = 0; i < 6; i++)
            send0({16'h1000 + 16'(i), 16'h0200}, 4'hF, 1'b1, 16'h0, 16'hEDFF - 16'(i), 1'b0, 1'b1);
        chk("tput_cycles", 32'(cyc - t0), 32'd6);
        drain();

        // Output stalled: two results fit, the third packet sees tready low.
        if0.axis_o_tready = 1'b0;
        send0(32'h0000_0001, 4'hF, 1'b1, 16'h0, 16'hFFFE, 1'b0, 1'b0);
        send0(32'h0000_0002, 4'hF, 1'b1, 16'h0, 16'hFFFD, 1'b0, 1'b0);
        #1;
        chk("bp_tready_low", 32'(if0.axis_i_tready), 32'd0);
        chk("bp_tvalid_held", 32'(if0.axis_o_tvalid), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("bp_tready_still_low", 32'(if0.axis_i_tready), 32'd0);
        chk("bp_tdata_held", 32'(if0.axis_o_tdata), 32'h0000_FFFE);
        @(negedge clk);
        if0.axis_o_tready = 1'b1;
        send0(32'h0000_0003, 4'hF, 1'b1, 16'h0, 16'hFFFC, 1'b0, 1'b0);
        drain();

        // Reset in the middle of a packet discards it; next packet uses its seed.
        send0(32'h1111_1111, 4'hF, 1'b0, 16'h2222, 16'h0, 1'b0, 1'b0);
        send0(32'h3333_3333, 4'hF, 1'b0, 16'h2222, 16'h0, 1'b0, 1'b0);
        sresetn = 1'b0;
        @(negedge clk);
        sresetn = 1'b1;
        #1;
        chk("midrst_tvalid", 32'(if0.axis_o_tvalid), 32'd0);
        chk("midrst_tready", 32'(if0.axis_i_tready), 32'd1);
        repeat (3) @(negedge clk);
        chk("midrst_no_output", 32'(if0.axis_o_tvalid), 32'd0);
        send0(32'h0001_0002, 4'hF, 1'b1, 16'h1234, 16'hEDC8, 1'b0, 1'b0);
        drain();

        // Random-length packets against the reference model.
        for (int p = 0; p < 8; p++) begin
            len = $urandom_range(1, 13);
            seed_r = 16'($urandom);
            bytes_q.delete();
            for (int i = 0; i < len; i++) bytes_q.push_back(8'($urandom));
            m = model(bytes_q, seed_r);
            nb = (len + 3) / 4;
            for (int bt = 0; bt < nb; bt++) begin
                d = '0; k = '0;
                for (int by = 0; by < 4; by++) begin
                    if (bt * 4 + by < len) begin
                        d[31 - 8*by -: 8] = bytes_q[bt*4 + by];
                        k[3 - by] = 1'b1;
                    end
                end
                send0(d, k, bt == nb - 1, seed_r, m[15:0], m[16], 1'b0);
            end
        end
        drain();

        // 70000 words of 0xFFFF: no carry may be lost.
        for (int i = 0; i < 35000; i++)
            send0(32'hFFFF_FFFF, 4'hF, i == 34999, 16'h0, 16'h0000, 1'b1, 1'b0);
        drain();

        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
